seq_add_sub: RTL

- Parametrised multi-cycle signed adder/subtractor. Processes DIGIT bits per clock, LSB digit first, over WIDTH/DIGIT cycles.
- Adds a subtract mode, optional saturation, a registered carry-out and a start/busy/done handshake.
- Sits in the datapath as the shared arithmetic unit for blocks that trade latency for area.

---
 rtl/seq_add_sub_pkg.sv | 28 ++
 rtl/seq_add_sub_digit_adder.sv | 14 +
 rtl/seq_add_sub.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/seq_add_sub_pkg.sv
// Shared types and constants for the digit-serial signed adder/subtractor.
// The saturation limits are computed from WIDTH so every instance shares one definition.
package seq_add_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DIGIT = 4;
  localparam int MAX_W     = 64;

  // Most-negative value (100..0) in the low w bits.
  function automatic logic [MAX_W-1:0] sat_neg(input int w);
    logic [MAX_W-1:0] r;
    r        = '0;
    r[w-1]   = 1'b1;
    return r;
  endfunction

  // Most-positive value (011..1) in the low w bits.
  function automatic logic [MAX_W-1:0] sat_pos(input int w);
    return sat_neg(w) - {{(MAX_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/seq_add_sub_digit_adder.sv
// Combinational DIGIT-bit ripple adder; the top reuses one instance for every digit.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             c_i,
  output logic [DIGIT-1:0] s_o,
  output logic             c_o
);

  assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{DIGIT{1'b0}}, c_i};

endmodule

// File: rtl/seq_add_sub.sv
// Digit-serial signed adder/subtractor: DIGIT bits per clock, LSB digit first,
// with optional saturation and a start/busy/done handshake.
module seq_add_sub
  import seq_add_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic             sat,
  input  logic             c_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             overflow,
  output logic             c_out,
  output logic [1:0]       dbg_state
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int SR_W  = (N > 1) ? WIDTH - DIGIT : 1;
  localparam logic [CNT_W-1:0] LAST      = CNT_W'(N - 1);
  localparam logic [MAX_W-1:0] SAT_NEG_W = sat_neg(WIDTH);
  localparam logic [MAX_W-1:0] SAT_POS_W = sat_pos(WIDTH);
  localparam logic [WIDTH-1:0] SAT_NEG   = SAT_NEG_W[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SAT_POS   = SAT_POS_W[WIDTH-1:0];

  if (DIGIT < 1 || (WIDTH % DIGIT) != 0 || WIDTH > MAX_W) begin : g_bad_params
    $fatal(1, "seq_add_sub: WIDTH must be a multiple of DIGIT (DIGIT >= 1, WIDTH <= MAX_W)");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               sat_q, sat_d;
  logic               a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               ovf_q, ovf_d, cout_q, cout_d;

  logic [DIGIT-1:0]   slice_s;
  logic               slice_c;
  logic [WIDTH-1:0]   raw;
  logic [SR_W-1:0]    sr_next;
  logic               raw_ovf;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a_i (a_q[DIGIT-1:0]),
    .b_i (b_q[DIGIT-1:0]),
    .c_i (carry_q),
    .s_o (slice_s),
    .c_o (slice_c)
  );

  // Result digits enter from the MSB side; after N digits raw holds the full word.
  if (N > 1) begin : g_multi
    assign raw     = {slice_s, sr_q};
    assign sr_next = raw[WIDTH-1:DIGIT];
  end else begin : g_single
    assign raw     = slice_s;
    assign sr_next = '0;
  end

  assign raw_ovf = (a_msb_q == b_msb_q) && (raw[WIDTH-1] != a_msb_q);

  // Handshake: start is sampled only in IDLE or DONE; busy is high for the N
  // digit cycles; done pulses for one cycle when sum/overflow/c_out are fresh.
  // Subtract mode is folded into b_eff and the initial carry at acceptance.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sat_d   = sat_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    cout_d  = cout_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d = ST_RUN;
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : c_in;
          sat_d   = sat;
          a_msb_d = a[WIDTH-1];
          b_msb_d = sub ? ~b[WIDTH-1] : b[WIDTH-1];
          cnt_d   = '0;
          sr_d    = '0;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = slice_c;
        sr_d    = sr_next;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          sum_d   = (sat_q && raw_ovf) ? (a_msb_q ? SAT_NEG : SAT_POS) : raw;
          ovf_d   = raw_ovf;
          cout_d  = slice_c;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sat_q   <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sat_q   <= sat_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      cout_q  <= cout_d;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign overflow  = ovf_q;
  assign c_out     = cout_q;
  assign dbg_state = state_q;

endmodule
